minrv32_mem_responder: RTL and testbench
========================================

MINRV32_MEM_RESPONDER -- requirements
Module: minrv32_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: memory depth in 32-bit words, power of two, 16..65536.
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra cycles before mem_ready, range 0..15.
REQ-003 SHALL have parameter ADDR_BASE, default 32'h0000_0000: byte address of word 0, 4-byte aligned.
REQ-004 SHALL have parameter ERR_RDATA, default 32'h0000_0013: read data for out-of-range reads (NOP encoding).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports: clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port: resetn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: mem_valid  input  1  initiator request.
REQ-008 SHALL have port: mem_instr  input  1  request is an instruction fetch; informational only.
REQ-009 SHALL have port: mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-010 SHALL have port: mem_wdata  input  32  write data.
REQ-011 SHALL have port: mem_wstrb  input  4  byte-lane write enables; 4'b0000 means read.
REQ-012 SHALL have port: mem_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: mem_rdata  output  32  read data, meaningful only while mem_ready=1.
REQ-014 SHALL have port: oob_err  output  1  sticky flag for an out-of-range access.
REQ-015 SHALL have port: proto_err  output  1  sticky flag for a protocol violation.
REQ-016 SHALL have port: xfer_count  output  32  number of completed transfers.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-018 In IDLE with mem_valid=1, SHALL latch mem_addr, mem_wdata, mem_wstrb and mem_instr, then go to WAIT if WAIT_STATES>0, else to RESP.
REQ-019 In WAIT, SHALL count WAIT_STATES cycles, then go to RESP; later changes on the address, data or strobe inputs are ignored (latched values used).
REQ-020 In RESP, SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency: mem_ready SHALL rise exactly WAIT_STATES+1 cycles after the first rising edge at which IDLE samples mem_valid=1.
REQ-022 A request still asserted in the cycle after RESP SHALL be accepted as a new transfer, giving back-to-back throughput of one transfer per WAIT_STATES+2 cycles.
REQ-023 Word index SHALL be (mem_addr-ADDR_BASE)>>2, using 32-bit unsigned subtraction; an access is in range iff mem_addr>=ADDR_BASE and index<MEM_WORDS.
REQ-024 An in-range write SHALL update only the byte lanes enabled by mem_wstrb, at the RESP edge; mem_rdata SHALL be 32'h0 during a write response.
REQ-025 An in-range read SHALL return the word contents as of the RESP cycle.
REQ-026 An out-of-range write SHALL leave memory unmodified.
REQ-027 An out-of-range read SHALL return ERR_RDATA.
REQ-028 Any out-of-range access SHALL still complete with mem_ready and SHALL set oob_err at the RESP edge.
REQ-029 If mem_valid drops while in WAIT, SHALL abort to IDLE on the next edge, with no write, no mem_ready and no count increment, and SHALL set proto_err.
REQ-030 mem_rdata SHALL be 32'h0 whenever mem_ready=0.
REQ-031 xfer_count SHALL increment by 1 at every RESP cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-032 oob_err and proto_err SHALL clear only on reset.

Reset
REQ-033 When resetn=0, SHALL immediately force state IDLE and mem_ready=0, mem_rdata=0, oob_err=0, proto_err=0, xfer_count=0, independent of clk.
REQ-034 Reset asserted in WAIT or RESP SHALL discard the pending transfer, with no memory write.
REQ-035 Memory array contents SHALL NOT be reset.
REQ-036 The first request SHALL be sampled on the first rising clk edge after resetn deasserts.

Verification
REQ-037 Write-then-read, WAIT_STATES=1: write 32'hA5A5_1234, strobe 4'hF, address 0x10, ready at cycle 2; read 0x10 -> mem_rdata=32'hA5A5_1234 at ready; xfer_count=2.
REQ-038 Byte lanes: word 0x20=32'h1122_3344; write 32'hFFFF_FFFF with strobe 4'b0101 -> read returns 32'h11FF_33FF.
REQ-039 Out of range, MEM_WORDS=1024: read 0x1000 -> ready asserted, rdata=32'h0000_0013, oob_err=1; a write to 0x1000 corrupts no word.
REQ-040 Protocol abort, WAIT_STATES=3: mem_valid dropped after 1 WAIT cycle -> no ready, proto_err=1, xfer_count unchanged, target word unchanged.
REQ-041 Reset mid-WAIT during a write to 0x40 (old value 32'h0) -> outputs at reset values immediately; after release, read 0x40 returns 32'h0.
REQ-042 Back-to-back, WAIT_STATES=0: mem_valid held high for 4 transfers -> ready pulses on alternate cycles; xfer_count=4.

Source files
------------

// File: rtl/minrv32_mem_responder.sv
// minrv32_mem_responder
//   Word-addressed memory target for a picorv32-style valid/ready bus. Each
//   request is latched in IDLE, held for WAIT_STATES cycles in WAIT, and
//   completed with a one-cycle mem_ready pulse in RESP.
//
// Ports
//   clk        sole clock, all state on the rising edge
//   resetn     asynchronous active-low reset
//   mem_valid  initiator request
//   mem_instr  instruction-fetch qualifier (informational only)
//   mem_addr   byte address; bits [1:0] ignored
//   mem_wdata  write data
//   mem_wstrb  byte-lane write enables; 4'b0000 means read
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data; zero unless mem_ready=1
//   oob_err    sticky: an access fell outside the memory window
//   proto_err  sticky: mem_valid dropped before completion
//   xfer_count completed transfers (wraps)
module minrv32_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        oob_err,
  output logic        proto_err,
  output logic [31:0] xfer_count
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, abort;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic        oob_q, proto_q;
  logic [31:0] count_q;

  logic [31:0] mem [MEM_WORDS];

  // 33-bit subtraction: the borrow bit flags addresses below ADDR_BASE.
  logic [32:0]   diff;
  logic [31:0]   word_idx;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_en;

  assign diff     = {1'b0, addr_q} - {1'b0, ADDR_BASE};
  assign word_idx = {2'b00, diff[31:2]};
  assign in_range = !diff[32] && (word_idx < MEM_WORDS);
  assign idx      = word_idx[AW-1:0];
  assign wr_en    = (state_q == RESP) && in_range && (wstrb_q != 4'b0000);

  logic [2:0] unused_bits;
  assign unused_bits = {instr_q, diff[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      oob_q   <= 1'b0;
      proto_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        instr_q <= mem_instr;
      end
      if (state_q == RESP) begin
        count_q <= count_q + 32'd1;
        if (!in_range) oob_q <= 1'b1;
      end
      if (abort) proto_q <= 1'b1;
    end
  end

  // Memory has no reset; reset forces IDLE so wr_en is already low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (state_q == RESP && wstrb_q == 4'b0000) begin
      mem_rdata = in_range ? mem[idx] : ERR_RDATA;
    end
  end

  assign mem_ready  = (state_q == RESP);
  assign oob_err    = oob_q;
  assign proto_err  = proto_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_minrv32_mem_responder.sv
module tb_minrv32_mem_responder;

  // Three configurations: [0] WS=1 1024 words base 0, [1] WS=3 16 words base 0x100,
  // [2] WS=0 1024 words base 0.
  localparam logic [2:0][31:0] WS_P   = {32'd0,    32'd3,      32'd1};
  localparam logic [2:0][31:0] MW_P   = {32'd1024, 32'd16,     32'd1024};
  localparam logic [2:0][31:0] BASE_P = {32'h0,    32'h100,    32'h0};

  logic        clk = 1'b0;
  logic        rstn  [3];
  logic        valid [3];
  logic        instr [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        oob   [3];
  logic        proto [3];
  logic [31:0] cnt   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    minrv32_mem_responder #(
      .MEM_WORDS  (MW_P[g]),
      .WAIT_STATES(WS_P[g]),
      .ADDR_BASE  (BASE_P[g]),
      .ERR_RDATA  (32'h0000_0013)
    ) u_dut (
      .clk       (clk),
      .resetn    (rstn[g]),
      .mem_valid (valid[g]),
      .mem_instr (instr[g]),
      .mem_addr  (addr[g]),
      .mem_wdata (wdata[g]),
      .mem_wstrb (wstrb[g]),
      .mem_ready (ready[g]),
      .mem_rdata (rdata[g]),
      .oob_err   (oob[g]),
      .proto_err (proto[g]),
      .xfer_count(cnt[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sparse memory keyed by (config, word), plus flag/count state.
  logic [31:0] mdl_mem [longint];
  int unsigned mdl_cnt   [3];
  bit          mdl_oob   [3];
  bit          mdl_proto [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint offset_of(input int id, input logic [31:0] a);
    return longint'({32'h0, a}) - longint'({32'h0, BASE_P[id]});
  endfunction

  function automatic bit in_rng(input int id, input logic [31:0] a);
    longint off = offset_of(id, a);
    return (off >= 0) && ((off / 4) < longint'(MW_P[id]));
  endfunction

  function automatic longint mkey(input int id, input logic [31:0] a);
    return longint'(id) * 64'h1_0000_0000 + offset_of(id, a) / 4;
  endfunction

  function automatic logic [31:0] pool(input int id, input int k);
    logic [31:0] p0 [6] = '{32'h0, 32'h4, 32'hFFC, 32'h800, 32'h1000, 32'hFFFF_FFFC};
    logic [31:0] p1 [6] = '{32'h100, 32'h13C, 32'h120, 32'hFC, 32'h140, 32'h0};
    logic [31:0] p2 [6] = '{32'h0, 32'h8, 32'hFFC, 32'h500, 32'h1000, 32'h2000};
    case (id)
      0:       return p0[k];
      1:       return p1[k];
      default: return p2[k];
    endcase
  endfunction

  task automatic mdl_apply(input int id, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic [31:0] cur;
    longint k = mkey(id, a);
    if (!in_rng(id, a)) mdl_oob[id] = 1'b1;
    else if (s != 4'b0000) begin
      cur = mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
      mdl_mem[k] = cur;
    end
    mdl_cnt[id]++;
  endtask

  function automatic logic [31:0] mdl_rdata(input int id, input logic [31:0] a,
                                            input logic [3:0] s);
    longint k = mkey(id, a);
    if (s != 4'b0000) return 32'h0;
    if (!in_rng(id, a)) return 32'h0000_0013;
    return mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
  endfunction

  task automatic chk_reset(input int id);
    chk($sformatf("rst%0d_ready", id), 32'(ready[id]), 32'h0);
    chk($sformatf("rst%0d_rdata", id), rdata[id], 32'h0);
    chk($sformatf("rst%0d_oob", id), 32'(oob[id]), 32'h0);
    chk($sformatf("rst%0d_proto", id), 32'(proto[id]), 32'h0);
    chk($sformatf("rst%0d_count", id), cnt[id], 32'h0);
  endtask

  // One complete transfer, starting at a negedge. Inputs other than mem_valid
  // are scrambled while waiting to show the latched copy is used.
  task automatic xfer(input int id, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] got);
    logic [31:0] exp_rd = mdl_rdata(id, a, s);
    int cyc = 0;
    bit seen = 1'b0;
    got = 32'h0;
    valid[id] = 1'b1; addr[id] = a; wdata[id] = d; wstrb[id] = s;
    instr[id] = (s == 4'b0000) ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ready[id]) begin
        seen = 1'b1;
        got = rdata[id];
        valid[id] = 1'b0;
      end else begin
        addr[id] = $urandom; wdata[id] = $urandom; wstrb[id] = 4'($urandom);
      end
    end
    valid[id] = 1'b0;
    chk($sformatf("d%0d_latency@%h", id, a), seen ? 32'(cyc) : 32'hFFFF_FFFF, WS_P[id] + 1);
    chk($sformatf("d%0d_rdata@%h", id, a), got, exp_rd);
    if (seen) mdl_apply(id, a, d, s);
    @(negedge clk);
    chk($sformatf("d%0d_ready_pulse", id), 32'(ready[id]), 32'h0);
    chk($sformatf("d%0d_rdata_idle", id), rdata[id], 32'h0);
    chk($sformatf("d%0d_count", id), cnt[id], mdl_cnt[id]);
    chk($sformatf("d%0d_oob", id), 32'(oob[id]), 32'(mdl_oob[id]));
    chk($sformatf("d%0d_proto", id), 32'(proto[id]), 32'(mdl_proto[id]));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_oob;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] got;
    int          pulses;
    logic [31:0] a, d;
    logic [3:0]  s;

    tbl[0]  = '{32'h10,   32'hA5A5_1234, 4'hF, 32'h0,         1'b0, 32'd1};
    tbl[1]  = '{32'h10,   32'h0,         4'h0, 32'hA5A5_1234, 1'b0, 32'd2};
    tbl[2]  = '{32'h20,   32'h1122_3344, 4'hF, 32'h0,         1'b0, 32'd3};
    tbl[3]  = '{32'h20,   32'hFFFF_FFFF, 4'h5, 32'h0,         1'b0, 32'd4};
    tbl[4]  = '{32'h20,   32'h0,         4'h0, 32'h11FF_33FF, 1'b0, 32'd5};
    tbl[5]  = '{32'h00,   32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 32'd6};
    tbl[6]  = '{32'h40,   32'h0000_0000, 4'hF, 32'h0,         1'b0, 32'd7};
    tbl[7]  = '{32'h1000, 32'h0,         4'h0, 32'h0000_0013, 1'b1, 32'd8};
    tbl[8]  = '{32'h1000, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1, 32'd9};
    tbl[9]  = '{32'h00,   32'h0,         4'h0, 32'hCAFE_F00D, 1'b1, 32'd10};
    tbl[10] = '{32'h13,   32'h0,         4'h0, 32'hA5A5_1234, 1'b1, 32'd11};
    tbl[11] = '{32'h42,   32'h0,         4'h0, 32'h0000_0000, 1'b1, 32'd12};

    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; valid[i] = 1'b0; instr[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
      mdl_cnt[i] = 0; mdl_oob[i] = 1'b0; mdl_proto[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) chk_reset(i);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;

    // Directed table on config 0; first request presented on the release edge.
    for (int i = 0; i < 12; i++) begin
      xfer(0, tbl[i].a, tbl[i].d, tbl[i].s, got);
      chk($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_oob", i), 32'(oob[0]), 32'(tbl[i].exp_oob));
      chk($sformatf("tbl%0d_count", i), cnt[0], tbl[i].exp_cnt);
    end

    // Reset while a write to 0x40 sits in WAIT.
    valid[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF;
    @(negedge clk);
    chk("rstwait_ready", 32'(ready[0]), 32'h0);
    chk("rstwait_oob_before", 32'(oob[0]), 32'h1);
    #2;
    rstn[0] = 1'b0; valid[0] = 1'b0;
    #1;
    chk_reset(0);
    mdl_cnt[0] = 0; mdl_oob[0] = 1'b0; mdl_proto[0] = 1'b0;
    @(negedge clk);
    rstn[0] = 1'b1;
    xfer(0, 32'h40, 32'h0, 4'h0, got);
    chk("rstwait_readback", got, 32'h0);

    // Protocol abort on config 1 (WS=3).
    xfer(1, 32'h104, 32'h1234_5678, 4'hF, got);
    valid[1] = 1'b1; addr[1] = 32'h104; wdata[1] = 32'hFFFF_FFFF; wstrb[1] = 4'hF;
    @(negedge clk);
    chk("abort_ready_wait", 32'(ready[1]), 32'h0);
    valid[1] = 1'b0;
    mdl_proto[1] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready[1]) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'h0);
    chk("abort_proto", 32'(proto[1]), 32'h1);
    chk("abort_count", cnt[1], 32'd1);
    xfer(1, 32'h104, 32'h0, 4'h0, got);
    chk("abort_word_kept", got, 32'h1234_5678);

    // Back-to-back writes on config 2 (WS=0), valid held high.
    pulses = 0;
    valid[2] = 1'b1; addr[2] = 32'h100; wdata[2] = 32'h1000_0000; wstrb[2] = 4'hF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), 32'(ready[2]), 32'(c % 2));
      if (ready[2]) begin
        chk($sformatf("b2b_rdata_c%0d", c), rdata[2], 32'h0);
        mdl_apply(2, 32'h100 + 32'(4 * pulses), 32'h1000_0000 + 32'(pulses), 4'hF);
        pulses++;
        if (pulses == 4) valid[2] = 1'b0;
        else begin
          addr[2] = 32'h100 + 32'(4 * pulses);
          wdata[2] = 32'h1000_0000 + 32'(pulses);
        end
      end
    end
    chk("b2b_count", cnt[2], 32'd4);
    xfer(2, 32'h108, 32'h0, 4'h0, got);
    chk("b2b_readback", got, 32'h1000_0002);

    // Randomized traffic against the model, pool words initialised first.
    for (int id = 0; id < 3; id++) begin
      for (int k = 0; k < 6; k++) xfer(id, pool(id, k), $urandom, 4'hF, got);
      for (int n = 0; n < 40; n++) begin
        a = pool(id, int'($urandom_range(0, 5))) | 32'($urandom_range(0, 3));
        d = $urandom;
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        xfer(id, a, d, s, got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
